// File: rtl/ps2_key_ctrl_funcmod_pkg.sv
// Shared definitions for the PS/2 key controller: scan-code-set-2 bytes,
// FSM states and the packed key event carried through the FIFO.
package ps2_key_ctrl_funcmod_pkg;

   localparam logic [7:0] BYTE_E0 = 8'hE0;
   localparam logic [7:0] BYTE_F0 = 8'hF0;
   localparam logic [7:0] BYTE_E1 = 8'hE1;
   localparam logic [7:0] BYTE_AA = 8'hAA;
   localparam logic [7:0] BYTE_FA = 8'hFA;
   localparam logic [7:0] BYTE_FE = 8'hFE;
   localparam logic [7:0] BYTE_EE = 8'hEE;
   localparam logic [7:0] BYTE_00 = 8'h00;
   localparam logic [7:0] BYTE_FF = 8'hFF;

   localparam int EVT_W = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXTBRK,
      ST_PAUSE
   } stateT;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } keyEvtT;

   function automatic logic [7:0] satInc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead synchronous FIFO for key events; head reads as zero when empty.
module ps2_evt_fifo
   import ps2_key_ctrl_funcmod_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             iPush,
   input  logic [EVT_W-1:0] iData,
   input  logic             iPop,
   output logic [EVT_W-1:0] oData,
   output logic             oFull,
   output logic             oEmpty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [EVT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic [AW:0]      count;
   logic             doPush;
   logic             doPop;

   assign oEmpty = (count == '0);
   assign oFull  = (count == FULL_CNT);
   assign doPop  = iPop && !oEmpty;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign doPush = iPush && (!oFull || doPop);
   assign oData  = oEmpty ? '0 : mem[rdPtr];

   always_ff @(posedge CLOCK) begin
      if (doPush) mem[wrPtr] <= iData;
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_ctrl_funcmod.sv
// Turns PS/2 receiver bytes into {ext, brk, code} key events with a prefix
// FSM, a stall watchdog, a saturating error counter and an event FIFO.
module ps2_key_ctrl_funcmod
   import ps2_key_ctrl_funcmod_pkg::*;
#(
   parameter int TIMEOUT_CYC = 100000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       iEnable,
   output logic       oRdEn,
   input  logic       iByteValid,
   input  logic [7:0] iByte,
   input  logic       iParityErr,
   output logic       oKeyValid,
   input  logic       iKeyReady,
   output logic [7:0] oKeyCode,
   output logic       oKeyExt,
   output logic       oKeyBrk,
   output logic       oOverflow,
   output logic [7:0] oErrCnt
);

   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYC - 1);

   stateT          state;
   stateT          nextState;
   logic [2:0]     pauseCnt;
   logic [2:0]     nextPause;
   logic [TW-1:0]  wdCnt;
   logic [7:0]     errCnt;
   logic           overflow;
   logic           evtHit;
   logic           errHit;
   keyEvtT         evt;
   keyEvtT         headEvt;
   logic           fifoPush;
   logic           fifoPop;
   logic           fifoFull;
   logic           fifoEmpty;

   // Byte decode; only takes effect on enabled byte-valid cycles.
   always_comb begin
      nextState = state;
      nextPause = pauseCnt;
      evtHit    = 1'b0;
      errHit    = 1'b0;
      evt       = '{ext: 1'b0, brk: 1'b0, code: iByte};
      case (state)
         ST_IDLE: begin
            case (iByte)
               BYTE_E0: nextState = ST_EXT;
               BYTE_F0: nextState = ST_BRK;
               BYTE_E1: begin
                  nextState = ST_PAUSE;
                  nextPause = 3'd7;
               end
               BYTE_AA, BYTE_FA, BYTE_FE, BYTE_EE: nextState = ST_IDLE;
               BYTE_00, BYTE_FF: errHit = 1'b1;
               default: evtHit = 1'b1;
            endcase
         end
         ST_EXT: begin
            if (iByte == BYTE_F0) nextState = ST_EXTBRK;
            else if (iByte != BYTE_E0) begin
               evtHit    = 1'b1;
               evt.ext   = 1'b1;
               nextState = ST_IDLE;
            end
         end
         ST_BRK, ST_EXTBRK: begin
            nextState = ST_IDLE;
            if (iByte == BYTE_E0 || iByte == BYTE_F0) errHit = 1'b1;
            else begin
               evtHit  = 1'b1;
               evt.ext = (state == ST_EXTBRK);
               evt.brk = 1'b1;
            end
         end
         ST_PAUSE: begin
            nextPause = pauseCnt - 3'd1;
            if (pauseCnt == 3'd1) begin
               evtHit    = 1'b1;
               evt       = '{ext: 1'b1, brk: 1'b0, code: BYTE_E1};
               nextState = ST_IDLE;
            end
         end
         default: nextState = ST_IDLE;
      endcase
      if (iParityErr) begin
         nextState = ST_IDLE;
         evtHit    = 1'b0;
         errHit    = 1'b1;
      end
   end

   assign fifoPush = iEnable && iByteValid && evtHit;
   assign fifoPop  = iKeyReady && !fifoEmpty;

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state    <= ST_IDLE;
         pauseCnt <= '0;
         wdCnt    <= '0;
         errCnt   <= '0;
         overflow <= 1'b0;
      end else begin
         if (!iEnable) begin
            state <= ST_IDLE;
            wdCnt <= '0;
         end else if (iByteValid) begin
            state    <= nextState;
            pauseCnt <= nextPause;
            wdCnt    <= '0;
            if (errHit) errCnt <= satInc(errCnt);
         end else if (state != ST_IDLE) begin
            if (wdCnt == WD_LAST) begin
               state  <= ST_IDLE;
               wdCnt  <= '0;
               errCnt <= satInc(errCnt);
            end else begin
               wdCnt <= wdCnt + 1'b1;
            end
         end else begin
            wdCnt <= '0;
         end
         if (fifoPush && fifoFull && !fifoPop) overflow <= 1'b1;
      end
   end

   ps2_evt_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .iPush  (fifoPush),
      .iData  (evt),
      .iPop   (fifoPop),
      .oData  (headEvt),
      .oFull  (fifoFull),
      .oEmpty (fifoEmpty)
   );

   assign oRdEn     = iEnable;
   assign oKeyValid = !fifoEmpty;
   assign oKeyCode  = headEvt.code;
   assign oKeyExt   = headEvt.ext;
   assign oKeyBrk   = headEvt.brk;
   assign oOverflow = overflow;
   assign oErrCnt   = errCnt;

endmodule

// File: tb/tb_ps2_key_ctrl_funcmod.sv
// Directed bench for the PS/2 key controller: prefix sequences, watchdog,
// parity/overrun errors, enable gating, FIFO overflow and error saturation.
module tb_ps2_key_ctrl_funcmod;

   localparam int TIMEOUT_CYC = 40;
   localparam int FIFO_DEPTH  = 4;

   logic       CLOCK;
   logic       RESET;
   logic       iEnable;
   logic       oRdEn;
   logic       iByteValid;
   logic [7:0] iByte;
   logic       iParityErr;
   logic       oKeyValid;
   logic       iKeyReady;
   logic [7:0] oKeyCode;
   logic       oKeyExt;
   logic       oKeyBrk;
   logic       oOverflow;
   logic [7:0] oErrCnt;

   int compCnt = 0;
   int mismatchCnt = 0;
   logic [9:0] expQ[$];

   ps2_key_ctrl_funcmod #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .iEnable    (iEnable),
      .oRdEn      (oRdEn),
      .iByteValid (iByteValid),
      .iByte      (iByte),
      .iParityErr (iParityErr),
      .oKeyValid  (oKeyValid),
      .iKeyReady  (iKeyReady),
      .oKeyCode   (oKeyCode),
      .oKeyExt    (oKeyExt),
      .oKeyBrk    (oKeyBrk),
      .oOverflow  (oOverflow),
      .oErrCnt    (oErrCnt)
   );

   // clock / reset
   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compCnt++;
      if (got !== exp) begin
         mismatchCnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic waitCyc(input int n);
      repeat (n) @(negedge CLOCK);
   endtask

   task automatic sendByte(input logic [7:0] b, input logic par);
      @(negedge CLOCK);
      iByteValid = 1'b1;
      iByte      = b;
      iParityErr = par;
      @(negedge CLOCK);
      iByteValid = 1'b0;
      iParityErr = 1'b0;
   endtask

   task automatic expectEvt(input logic ext, input logic brk, input logic [7:0] code);
      expQ.push_back({ext, brk, code});
   endtask

   // Compare the head against the scoreboard, then pop it.
   task automatic popCheck(input string tag);
      logic [9:0] exp;
      exp = expQ.pop_front();
      checkVal({tag, " valid"}, 32'(oKeyValid), 32'd1);
      checkVal({tag, " event"}, 32'({oKeyExt, oKeyBrk, oKeyCode}), 32'(exp));
      @(negedge CLOCK);
      iKeyReady = 1'b1;
      @(negedge CLOCK);
      iKeyReady = 1'b0;
   endtask

   initial begin
      RESET      = 1'b0;
      iEnable    = 1'b0;
      iByteValid = 1'b0;
      iByte      = 8'h00;
      iParityErr = 1'b0;
      iKeyReady  = 1'b0;
      waitCyc(3);
      checkVal("rst valid", 32'(oKeyValid), 32'd0);
      checkVal("rst code", 32'(oKeyCode), 32'd0);
      checkVal("rst ext", 32'(oKeyExt), 32'd0);
      checkVal("rst brk", 32'(oKeyBrk), 32'd0);
      checkVal("rst ovf", 32'(oOverflow), 32'd0);
      checkVal("rst errcnt", 32'(oErrCnt), 32'd0);
      checkVal("rden off", 32'(oRdEn), 32'd0);
      RESET = 1'b1;
      waitCyc(2);
      iEnable = 1'b1;
      waitCyc(1);
      checkVal("rden on", 32'(oRdEn), 32'd1);

      // plain make code, one-cycle latency
      checkVal("idle valid", 32'(oKeyValid), 32'd0);
      sendByte(8'h1C, 1'b0);
      expectEvt(1'b0, 1'b0, 8'h1C);
      popCheck("make 1C");
      checkVal("empty after pop", 32'(oKeyValid), 32'd0);

      // break
      sendByte(8'hF0, 1'b0);
      checkVal("no evt after F0", 32'(oKeyValid), 32'd0);
      sendByte(8'h1C, 1'b0);
      expectEvt(1'b0, 1'b1, 8'h1C);
      popCheck("brk 1C");

      // extended break, then ignored BAT byte
      sendByte(8'hE0, 1'b0);
      sendByte(8'hF0, 1'b0);
      checkVal("no evt after E0F0", 32'(oKeyValid), 32'd0);
      sendByte(8'h75, 1'b0);
      expectEvt(1'b1, 1'b1, 8'h75);
      popCheck("extbrk 75");
      sendByte(8'hAA, 1'b0);
      checkVal("AA ignored", 32'(oKeyValid), 32'd0);
      checkVal("AA no err", 32'(oErrCnt), 32'd0);

      // watchdog
      sendByte(8'hE0, 1'b0);
      waitCyc(TIMEOUT_CYC - 3);
      checkVal("wd before", 32'(oErrCnt), 32'd0);
      waitCyc(5);
      checkVal("wd after", 32'(oErrCnt), 32'd1);
      sendByte(8'h1C, 1'b0);
      expectEvt(1'b0, 1'b0, 8'h1C);
      popCheck("post wd 1C");

      // parity error, then pause sequence
      sendByte(8'h1C, 1'b1);
      checkVal("parity no evt", 32'(oKeyValid), 32'd0);
      checkVal("parity err", 32'(oErrCnt), 32'd2);
      sendByte(8'hE1, 1'b0);
      sendByte(8'h14, 1'b0);
      sendByte(8'h77, 1'b0);
      sendByte(8'hE1, 1'b0);
      sendByte(8'hF0, 1'b0);
      sendByte(8'h14, 1'b0);
      sendByte(8'hF0, 1'b0);
      checkVal("pause partial", 32'(oKeyValid), 32'd0);
      sendByte(8'h77, 1'b0);
      expectEvt(1'b1, 1'b0, 8'hE1);
      popCheck("pause");
      checkVal("pause single", 32'(oKeyValid), 32'd0);

      // overrun byte and double prefix after F0
      sendByte(8'h00, 1'b0);
      checkVal("overrun err", 32'(oErrCnt), 32'd3);
      sendByte(8'hF0, 1'b0);
      sendByte(8'hE0, 1'b0);
      checkVal("F0E0 err", 32'(oErrCnt), 32'd4);
      sendByte(8'h1C, 1'b0);
      expectEvt(1'b0, 1'b0, 8'h1C);
      popCheck("post F0E0");

      // enable low clears a partial prefix and ignores bytes
      sendByte(8'hE0, 1'b0);
      iEnable = 1'b0;
      sendByte(8'h1C, 1'b0);
      checkVal("rden low", 32'(oRdEn), 32'd0);
      checkVal("disabled no evt", 32'(oKeyValid), 32'd0);
      iEnable = 1'b1;
      sendByte(8'h1C, 1'b0);
      expectEvt(1'b0, 1'b0, 8'h1C);
      popCheck("post enable");

      // FIFO overflow with consumer stalled
      sendByte(8'h15, 1'b0);
      sendByte(8'h1D, 1'b0);
      sendByte(8'h24, 1'b0);
      sendByte(8'h2D, 1'b0);
      checkVal("full no ovf", 32'(oOverflow), 32'd0);
      sendByte(8'h2C, 1'b0);
      checkVal("ovf set", 32'(oOverflow), 32'd1);
      waitCyc(3);
      checkVal("head stable", 32'(oKeyCode), 32'h15);
      expectEvt(1'b0, 1'b0, 8'h15);
      expectEvt(1'b0, 1'b0, 8'h1D);
      expectEvt(1'b0, 1'b0, 8'h24);
      expectEvt(1'b0, 1'b0, 8'h2D);
      for (int i = 0; i < 4; i++) popCheck($sformatf("drain %0d", i));
      checkVal("drained", 32'(oKeyValid), 32'd0);
      checkVal("ovf sticky", 32'(oOverflow), 32'd1);

      // error counter saturation
      for (int i = 0; i < 260; i++) sendByte(8'h1C, 1'b1);
      checkVal("err saturate", 32'(oErrCnt), 32'hFF);
      checkVal("sat no evt", 32'(oKeyValid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, mismatchCnt);
      $finish;
   end

endmodule
